vc_arbiter: RTL and testbench

//  Round-robin scheduler between the 4 virtual-channel FIFOs and the 2 destination FIFOs.

---
 rtl/vc_arbiter.sv | 129 ++++++++++++
 tb/tb_vc_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// Round-robin scheduler that moves head words from four virtual-channel FIFOs
// into two destination FIFOs, gated by the interconnect control FSM.
module vc_arbiter #(
  parameter int DATA_W   = 6,
  parameter int DEST_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  enable,
  input  logic                  halt_i,
  input  logic [3:0]            vc_empty,
  input  logic [4*DATA_W-1:0]   vc_data,
  input  logic [1:0]            af_d,
  output logic [3:0]            vc_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_W-1:0]     d_data,
  output logic [1:0]            grant_vc,
  output logic                  busy,
  output logic                  arb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [1:0]          rr_ptr;
  logic [3:0]          elig;
  logic                go;
  logic                found;
  logic                grant;
  logic [1:0]          winner;
  logic [DATA_W-1:0]   win_word;
  logic                win_dest;

  // A VC is eligible when it has a word and that word's destination can take it.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = !vc_empty[i] && !af_d[vc_data[i*DATA_W + DEST_BIT]];
    end
  end

  assign go = (state == ARB) && enable && !init && !halt_i;

  // Search starts just past the last winner so every VC gets a turn.
  always_comb begin
    logic [1:0] cand;
    found  = 1'b0;
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant    = go && found;
  assign win_word = vc_data[int'(winner)*DATA_W +: DATA_W];
  assign win_dest = win_word[DEST_BIT];

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_L) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; halt_i outranks init, which outranks enable.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (halt_i)                next_state = ERR;
        else if (enable && !init)  next_state = ARB;
      end
      ARB: begin
        if (halt_i)                next_state = ERR;
        else if (init || !enable)  next_state = IDLE;
      end
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  // FSM output: one-hot pop, only while arbitration is allowed this cycle.
  always_comb begin
    vc_pop = '0;
    if (grant) vc_pop[winner] = 1'b1;
  end

  // Registered datapath toward the destination FIFOs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr   <= 2'd3;
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      d_data   <= '0;
      grant_vc <= '0;
      busy     <= 1'b0;
      arb_err  <= 1'b0;
    end else begin
      d0_push <= grant && !win_dest;
      d1_push <= grant &&  win_dest;
      busy    <= (next_state == ARB);
      arb_err <= (next_state == ERR);
      if (grant) begin
        rr_ptr   <= winner;
        d_data   <= win_word;
        grant_vc <= winner;
      end else if (init && state != ERR) begin
        // Restart the rotation so VC0 is first after re-initialisation.
        rr_ptr <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: the bench plays the VC FIFOs with queues
// and predicts pops and pushes from a round-robin reference model.
module tb_vc_arbiter;
  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;

  logic                clk = 1'b0;
  logic                reset_L = 1'b0;
  logic                init = 1'b0;
  logic                enable = 1'b0;
  logic                halt_i = 1'b0;
  logic [3:0]          vc_empty = 4'hF;
  logic [4*DATA_W-1:0] vc_data = '0;
  logic [1:0]          af_d = 2'b00;
  logic [3:0]          vc_pop;
  logic                d0_push;
  logic                d1_push;
  logic [DATA_W-1:0]   d_data;
  logic [1:0]          grant_vc;
  logic                busy;
  logic                arb_err;

  vc_arbiter #(.DATA_W(DATA_W), .DEST_BIT(DEST_BIT)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .enable(enable), .halt_i(halt_i),
    .vc_empty(vc_empty), .vc_data(vc_data), .af_d(af_d), .vc_pop(vc_pop),
    .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data), .grant_vc(grant_vc),
    .busy(busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: VC FIFO contents plus the scheduler's observable state.
  logic [DATA_W-1:0] vcq [4][$];
  bit                m_active;
  bit                m_error;
  int                m_last;
  bit                e_d0;
  bit                e_d1;
  logic [DATA_W-1:0] e_data;
  int                e_gvc;
  logic [3:0]        obs_pop;

  function automatic logic [DATA_W-1:0] mk_word(input int dest);
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom);
    if (dest >= 0) w[DEST_BIT] = dest[0];
    return w;
  endfunction

  task automatic fill(input int vc, input int n, input int dest);
    for (int j = 0; j < n; j++) vcq[vc].push_back(mk_word(dest));
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) vcq[i].delete();
  endtask

  task automatic drive_vc();
    for (int i = 0; i < 4; i++) begin
      if (vcq[i].size() > 0) begin
        vc_empty[i] = 1'b0;
        vc_data[i*DATA_W +: DATA_W] = vcq[i][0];
      end else begin
        vc_empty[i] = 1'b1;
        vc_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    end
  endtask

  // One clock: predict this cycle's pop, advance the model, compare registers.
  task automatic cycle(input string tag);
    logic [3:0]        elig;
    logic [3:0]        exp_pop;
    logic [DATA_W-1:0] h;
    int                win;
    bit                go;
    drive_vc();
    #1;
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      if (vcq[i].size() > 0) begin
        h = vcq[i][0];
        elig[i] = !af_d[h[DEST_BIT]];
      end
    end
    go  = m_active && enable && !init && !halt_i;
    win = -1;
    if (go) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (win < 0 && elig[c]) win = c;
      end
    end
    exp_pop = (win >= 0) ? 4'(1 << win) : 4'b0000;
    obs_pop = vc_pop;
    checks++;
    if (vc_pop !== exp_pop) begin
      failures++;
      $display("FAIL %s vc_pop got=%b exp=%b", tag, vc_pop, exp_pop);
    end
    if (!m_error) begin
      if (halt_i) begin
        m_error  = 1'b1;
        m_active = 1'b0;
      end else begin
        m_active = enable && !init;
        if (init) m_last = 3;
      end
    end
    if (win >= 0) begin
      h      = vcq[win].pop_front();
      e_data = h;
      e_gvc  = win;
      e_d0   = !h[DEST_BIT];
      e_d1   = h[DEST_BIT];
      m_last = win;
    end else begin
      e_d0 = 1'b0;
      e_d1 = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if ({d0_push, d1_push} !== {e_d0, e_d1}) begin
      failures++;
      $display("FAIL %s push got=%b%b exp=%b%b", tag, d0_push, d1_push, e_d0, e_d1);
    end
    checks++;
    if (d_data !== e_data || grant_vc !== 2'(e_gvc)) begin
      failures++;
      $display("FAIL %s data/grant got=%h/%0d exp=%h/%0d", tag, d_data, grant_vc, e_data, e_gvc);
    end
    checks++;
    if (busy !== m_active || arb_err !== m_error) begin
      failures++;
      $display("FAIL %s busy/err got=%b/%b exp=%b/%b", tag, busy, arb_err, m_active, m_error);
    end
  endtask

  // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    init   = 1'b0;
    halt_i = 1'b0;
    #3 reset_L = 1'b0;
    #1;
    m_active = 1'b0;
    m_error  = 1'b0;
    m_last   = 3;
    e_d0     = 1'b0;
    e_d1     = 1'b0;
    e_data   = '0;
    e_gvc    = 0;
    checks++;
    if ({d0_push, d1_push, d_data, grant_vc, busy, arb_err} !== '0) begin
      failures++;
      $display("FAIL reset_regs got=%b%b %h %0d %b%b", d0_push, d1_push, d_data, grant_vc,
               busy, arb_err);
    end
    checks++;
    if (vc_pop !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pop got=%b exp=0000", vc_pop);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    clear_all();
    apply_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [6];
    seq = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    clear_all();
    for (int i = 0; i < 4; i++) fill(i, 8, 0);
    af_d   = 2'b00;
    enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle("rr");
      checks++;
      if (obs_pop !== seq[n]) begin
        failures++;
        $display("FAIL rr_order step %0d got=%b exp=%b", n, obs_pop, seq[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    apply_reset();
    clear_all();
    fill(0, 10, 0);
    fill(2, 10, 0);
    fill(3, 10, 0);
    fill(1, 1, 1);
    af_d   = 2'b10;
    enable = 1'b1;
    for (int n = 0; n < 9; n++) begin
      cycle("bp_blocked");
      checks++;
      if (obs_pop[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_vc1_blocked got=%b exp=0", obs_pop[1]);
      end
    end
    af_d = 2'b00;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      cycle("bp_release");
      if (obs_pop[1]) begin
        seen = 1'b1;
        checks++;
        if (d1_push !== 1'b1) begin
          failures++;
          $display("FAIL bp_d1_push got=%b exp=1", d1_push);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_vc1_granted got=0 exp=1 within 4 cycles");
    end
  endtask

  task automatic test_single_vc();
    apply_reset();
    clear_all();
    fill(2, 3, -1);
    af_d   = 2'b00;
    enable = 1'b1;
    cycle("single_idle");
    for (int n = 0; n < 3; n++) begin
      cycle("single");
      checks++;
      if (obs_pop !== 4'b0100) begin
        failures++;
        $display("FAIL single_vc2 got=%b exp=0100", obs_pop);
      end
    end
    fill(0, 2, -1);
    fill(3, 2, -1);
    cycle("single_next");
    checks++;
    if (obs_pop !== 4'b1000) begin
      failures++;
      $display("FAIL single_vc3_first got=%b exp=1000", obs_pop);
    end
    cycle("single_after");
  endtask

  task automatic test_halt();
    apply_reset();
    clear_all();
    for (int i = 0; i < 4; i++) fill(i, 6, -1);
    af_d   = 2'b00;
    enable = 1'b1;
    for (int n = 0; n < 4; n++) cycle("halt_pre");
    halt_i = 1'b1;
    cycle("halt");
    halt_i = 1'b0;
    checks++;
    if (obs_pop !== 4'b0000 || arb_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_effect got pop=%b err=%b busy=%b exp 0000/1/0", obs_pop, arb_err, busy);
    end
    for (int n = 0; n < 6; n++) begin
      enable = 1'($urandom);
      init   = 1'($urandom);
      cycle("halt_sticky");
    end
    init = 1'b0;
    checks++;
    if (arb_err !== 1'b1) begin
      failures++;
      $display("FAIL halt_sticky_err got=%b exp=1", arb_err);
    end
  endtask

  task automatic test_init();
    bit seen;
    apply_reset();
    clear_all();
    for (int i = 0; i < 4; i++) fill(i, 8, 0);
    af_d   = 2'b00;
    enable = 1'b1;
    for (int n = 0; n < 3; n++) cycle("init_pre");
    init = 1'b1;
    cycle("init_hold");
    checks++;
    if (obs_pop !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL init_gate got pop=%b busy=%b exp 0000/0", obs_pop, busy);
    end
    cycle("init_hold");
    init = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      cycle("init_release");
      if (obs_pop != 4'b0000) begin
        seen = 1'b1;
        checks++;
        if (obs_pop !== 4'b0001) begin
          failures++;
          $display("FAIL init_first_grant got=%b exp=0001", obs_pop);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL init_no_grant got=none exp=0001 within 4 cycles");
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    for (int i = 0; i < 4; i++) fill(i, 6, -1);
    af_d   = 2'b00;
    enable = 1'b1;
    for (int n = 0; n < 3; n++) cycle("arst_pre");
    apply_reset();
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      cycle("arst_release");
      if (obs_pop != 4'b0000) begin
        seen = 1'b1;
        checks++;
        if (obs_pop !== 4'b0001) begin
          failures++;
          $display("FAIL arst_first_grant got=%b exp=0001", obs_pop);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL arst_no_grant got=none exp=0001 within 4 cycles");
    end
  endtask

  task automatic test_random();
    apply_reset();
    clear_all();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(1, 0) == 1 && vcq[i].size() < 8) fill(i, 1, -1);
      end
      af_d   = 2'($urandom);
      enable = ($urandom_range(7, 0) != 0);
      init   = ($urandom_range(15, 0) == 0);
      cycle("random");
    end
    init = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_vc();
    test_halt();
    test_init();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
